mem_access_unit: RTL and testbench

- Load/store stage between the execute stage and the single-ported, word-addressed data memory (32 x 32-bit words, registered read, write priority over read, reset clears only its read register).
- Accepts byte/half/word load and store requests over a valid/ready handshake and turns each into memory Read/Write strobes.
- Performs read-modify-write for sub-word stores, plus lane extraction and sign/zero extension for loads.
- Returns one response per request.

---
 rtl/mem_access_unit.sv | 187 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store stage between execute and a word-addressed data memory: sub-word RMW
// stores, lane extraction/extension for loads. Optional macro: MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int MEM_WORDS = 32,
  parameter int IDX_W     = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] data_q, data_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_read_q, mem_read_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        req_err;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      2'b00:   res = uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   res = off[1] ? (uns ? {16'b0, word[31:16]} : {{16{word[31]}}, word[31:16]})
                            : (uns ? {16'b0, word[15:0]}  : {{16{word[15]}}, word[15:0]});
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] size,
                                        input logic [1:0] off, input logic [15:0] wd);
    logic [31:0] res;
    res = word;
    if (size == 2'b00) res[{off, 3'b000} +: 8] = wd[7:0];
    else if (off[1])   res[31:16] = wd;
    else               res[15:0]  = wd;
    return res;
  endfunction

  always_comb begin
    req_err = (req_addr >= 32'(MEM_WORDS * 4)) || (req_size == 2'b11);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    if ((req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`endif
  end

  assign req_ready = (state_q == IDLE);

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    data_d       = data_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      IDLE: if (req_valid) begin
        write_d    = req_write;
        size_d     = req_size;
        uns_d      = req_unsigned;
        off_d      = req_addr[1:0];
        wdata_d    = req_wdata[15:0];
        err_d      = req_err;
        data_d     = '0;
        if (req_err) begin
          state_d = RESP;
        end else begin
          mem_addr_d = 32'(req_addr[IDX_W+1:2]);
          if (req_write && req_size == 2'b10) begin
            mem_wdata_d = req_wdata;
            mem_write_d = 1'b1;
            state_d     = WR;
          end else begin
            mem_read_d = 1'b1;
            state_d    = RD;
          end
        end
      end
      RD: state_d = RD_WAIT;
      RD_WAIT: begin
        if (!write_q) begin
          data_d  = extract(mem_rdata, size_q, off_q, uns_q);
          state_d = RESP;
        end else begin
          mem_wdata_d = merge(mem_rdata, size_q, off_q, wdata_q);
          mem_write_d = 1'b1;
          state_d     = WR;
        end
      end
      WR: state_d = RESP;
      RESP: begin
        // Response registers are loaded here, so the pulse appears as the unit re-enters IDLE.
        resp_valid_d = 1'b1;
        resp_error_d = err_q;
        resp_rdata_d = data_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      data_q       <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      data_q       <= data_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_write  = mem_write_q;
  assign mem_read   = mem_read_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 32x32 data memory
// (registered read, write over read, reset clears only the read register).
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] bmem [32];

  mem_access_unit dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!reset) mem_rdata <= '0;
    else if (mem_write) bmem[mem_addr[4:0]] <= mem_wdata;
    else if (mem_read) mem_rdata <= bmem[mem_addr[4:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request; negedge i after the accept edge E samples the cycle following edge E+i.
  task automatic xact(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    int pulses;
    logic saw_rd, saw_wr;
    logic [31:0] got_rdata;
    logic got_err;
    lat = -1; pulses = 0; saw_rd = 1'b0; saw_wr = 1'b0; got_rdata = '0; got_err = 1'b0;
    @(negedge clock);
    check({tag, "/ready_idle"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      saw_rd |= mem_read;
      saw_wr |= mem_write;
      if (i == 0) begin
        check({tag, "/ready_busy"}, {31'b0, req_ready}, 32'd0);
        if (!exp_err) check({tag, "/mem_addr"}, mem_addr, {27'b0, addr[6:2]});
      end
      if (resp_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = i; got_rdata = resp_rdata; got_err = resp_error;
        end
      end
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/pulses"}, 32'(pulses), 32'd1);
    check({tag, "/rdata"}, got_rdata, exp_rdata);
    check({tag, "/error"}, {31'b0, got_err}, {31'b0, exp_err});
    check({tag, "/rd_strobe"}, {31'b0, saw_rd}, {31'b0, !exp_err && !(wr && sz == 2'b10)});
    check({tag, "/wr_strobe"}, {31'b0, saw_wr}, {31'b0, !exp_err && wr});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic busy;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

    // Reset held 3 cycles with a request pulsed in the middle.
    busy = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'h0BAD_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      req_valid = 1'b0;
      busy |= mem_read | mem_write | resp_valid;
    end
    check("reset/no_activity", {31'b0, busy}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("reset/flags", {26'b0, req_ready, resp_valid, resp_error, mem_write, mem_read, 1'b0}, 32'h20);
    check("reset/resp_rdata", resp_rdata, 32'h0);
    check("reset/mem_addr", mem_addr, 32'h0);
    check("reset/mem_wdata", mem_wdata, 32'h0);

    xact("st_w_10",    1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 2, 32'h0, 1'b0);
    xact("ld_w_10",    1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         3, 32'hDEAD_BEEF, 1'b0);
    xact("st_b_11",    1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FF80, 4, 32'h0, 1'b0);
    xact("ld_w_10b",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         3, 32'hDEAD_80EF, 1'b0);
    xact("ld_bs_11",   1'b0, 2'b00, 1'b0, 32'h11, 32'h0,         3, 32'hFFFF_FF80, 1'b0);
    xact("ld_bu_11",   1'b0, 2'b00, 1'b1, 32'h11, 32'h0,         3, 32'h0000_0080, 1'b0);
    xact("ld_hs_12",   1'b0, 2'b01, 1'b0, 32'h12, 32'h0,         3, 32'hFFFF_DEAD, 1'b0);
    xact("st_h_12",    1'b1, 2'b01, 1'b0, 32'h12, 32'hAAAA_1234, 4, 32'h0, 1'b0);
    xact("ld_w_10c",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         3, 32'h1234_80EF, 1'b0);
    xact("ld_hu_10",   1'b0, 2'b01, 1'b1, 32'h10, 32'h0,         3, 32'h0000_80EF, 1'b0);
    xact("ld_bs_13",   1'b0, 2'b00, 1'b0, 32'h13, 32'h0,         3, 32'h0000_0012, 1'b0);
    xact("err_range",  1'b0, 2'b10, 1'b0, 32'h80, 32'h0,         1, 32'h0, 1'b1);
    xact("err_size",   1'b0, 2'b11, 1'b0, 32'h00, 32'h0,         1, 32'h0, 1'b1);
    xact("err_st_rng", 1'b1, 2'b00, 1'b0, 32'hFFFF_FFFC, 32'h55, 1, 32'h0, 1'b1);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    xact("ld_hs_13",   1'b0, 2'b01, 1'b0, 32'h13, 32'h0,         1, 32'h0, 1'b1);
`else
    xact("ld_hs_13",   1'b0, 2'b01, 1'b0, 32'h13, 32'h0,         3, 32'h0000_1234, 1'b0);
`endif

    // Reset asserted while the write strobe of a byte RMW is high.
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_wr/strobe", {31'b0, mem_write}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check("rst_wr/idle", {28'b0, req_ready, resp_valid, mem_write, mem_read}, 32'h8);
    reset = 1'b1;
    busy = 1'b0;
    repeat (4) begin
      @(negedge clock);
      busy |= resp_valid | mem_write | mem_read;
    end
    check("rst_wr/no_resp", {31'b0, busy}, 32'd0);
    check("rst_wr/mem_word", bmem[4], 32'h1234_80EF);
    xact("ld_w_after", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         3, 32'h1234_80EF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
